// File: rtl/dct_noc_pkg.sv
// Shared NoC/DCT tile types: mesh geometry, payload width and the return tag
// that records which requester owns each block in flight through the engine.
package dct_noc_pkg;

    localparam int X          = 4;
    localparam int Y          = 4;
    localparam int DATA_WIDTH = 256;
    localparam int PCK_NUM    = 12;
    localparam int N_REQ      = 4;

    localparam int x_size = $clog2(X);
    localparam int y_size = $clog2(Y);
    localparam int HDR_W  = x_size + y_size + PCK_NUM;
    localparam int SRC_W  = $clog2(N_REQ);

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [x_size-1:0]  x;
        logic [y_size-1:0]  y;
        logic [PCK_NUM-1:0] pck;
    } dct_tag_t;

endpackage

// File: rtl/dct_tag_fifo.sv
// Synchronous tag FIFO; push and pop may coincide, push while full and pop
// while empty are ignored.
module dct_tag_fifo
    import dct_noc_pkg::*;
#(
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  dct_tag_t                   push_tag,
    input  logic                       pop,
    output dct_tag_t                   head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(TAG_DEPTH):0] count
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(TAG_DEPTH);

    dct_tag_t        mem [TAG_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_en;
    logic            pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/dct_scheduler.sv
// Round-robin sharing of one dct engine among N_REQ NoC requesters; results
// return in order to their source with the request header echoed.
module dct_scheduler
    import dct_noc_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 256,
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int PCK_NUM    = 12,
    parameter int TAG_DEPTH  = 8,
    localparam int HDR_W     = $clog2(X) + $clog2(Y) + PCK_NUM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ*HDR_W-1:0]      req_hdr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       eng_i_data,
    output logic                        eng_i_valid,
    input  logic                        eng_i_ready,
    input  logic [DATA_WIDTH-1:0]       eng_o_data,
    input  logic                        eng_o_valid,
    output logic                        eng_o_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [HDR_W-1:0]            rsp_hdr,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic                        err
);

    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [SRC_W-1:0]            rr_ptr;
    logic [SRC_W-1:0]            win;
    logic [SRC_W-1:0]            idx;
    logic                        win_found;
    logic                        can_accept;
    logic                        accept;
    logic [DATA_WIDTH-1:0]       hold_data_p1;
    logic                        hold_vld_p1;
    dct_tag_t                    tag_in;
    dct_tag_t                    tag_head;
    logic                        tag_full;
    logic                        tag_empty;
    logic                        tag_pop;
    logic [$clog2(TAG_DEPTH):0]  tag_count;

    always_comb begin
        win       = rr_ptr;
        idx       = rr_ptr;
        win_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    assign can_accept = !tag_full && (!hold_vld_p1 || eng_i_ready);
    assign accept     = win_found && can_accept;
    assign req_ready  = accept ? (N_REQ'(1) << win) : '0;
    assign tag_in     = {win, req_hdr[int'(win)*HDR_W +: HDR_W]};

    // Stage p1: holding register feeding the engine
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            hold_vld_p1 <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (accept) begin
                hold_vld_p1 <= 1'b1;
                rr_ptr      <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            end else if (eng_i_ready) begin
                hold_vld_p1 <= 1'b0;
            end
            if (eng_o_valid && tag_count == '0) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) hold_data_p1 <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eng_i_data  = hold_data_p1;
    assign eng_i_valid = hold_vld_p1;

    // Return path is combinational from the oldest outstanding tag
    assign eng_o_ready = !tag_empty && rsp_ready[tag_head.src];
    assign tag_pop     = eng_o_valid && eng_o_ready;
    assign rsp_valid   = (eng_o_valid && !tag_empty) ? (N_REQ'(1) << tag_head.src) : '0;
    assign rsp_hdr     = {tag_head.x, tag_head.y, tag_head.pck};
    assign rsp_data    = eng_o_data;

    dct_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_tag (tag_in),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

endmodule

// File: tb/tb_dct_scheduler.sv
// Bench for dct_scheduler: directed vectors plus randomized traffic against a
// queue-based reference model and a simple in-order engine stand-in.
module tb_dct_scheduler;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int HW = 16;
    localparam logic [DW-1:0] MASK = {32{8'hB4}};

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*HW-1:0] req_hdr;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   eng_i_data;
    logic            eng_i_valid;
    logic            eng_i_ready;
    logic [DW-1:0]   eng_o_data;
    logic            eng_o_valid;
    logic            eng_o_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [HW-1:0]   rsp_hdr;
    logic [N-1:0]    rsp_ready;
    logic            err;

    dct_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_hdr(req_hdr), .req_ready(req_ready),
        .eng_i_data(eng_i_data), .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
        .eng_o_data(eng_o_data), .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hdr(rsp_hdr), .rsp_ready(rsp_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            src;
        logic [HW-1:0] hdr;
    } tag_t;

    typedef struct {
        logic [N-1:0] rv;
        bit           eir;
        logic [N-1:0] exp_ready;
    } vec_t;

    // Reference model state
    tag_t          tags[$];
    logic [DW-1:0] eng_q[$];
    int            rr_m;
    bit            hold_v;
    logic [DW-1:0] hold_d;
    bit            err_m;

    // Stimulus knobs
    logic [N-1:0]  rv, rr_in;
    logic [DW-1:0] d_a[N];
    logic [HW-1:0] h_a[N];
    bit            eir, eov_req, force_eov, rst_in;

    // Observed DUT outputs of the latest cycle
    logic [N-1:0]  obs_req_ready, obs_rsp_valid;
    logic [DW-1:0] obs_eng_i_data, obs_rsp_data;
    logic [HW-1:0] obs_rsp_hdr;
    logic          obs_eng_i_valid, obs_eng_o_ready, obs_err;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int j = 0; j < DW / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        tags.delete();
        eng_q.delete();
        rr_m   = 0;
        hold_v = 0;
        err_m  = 0;
    endtask

    task automatic cycle();
        int           w;
        bit           acc;
        bit           eov;
        logic [N-1:0] exp_rr, exp_rv;
        bit           exp_eor;
        @(negedge clk);
        rst       = rst_in;
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = d_a[i];
            req_hdr[i*HW +: HW]  = h_a[i];
        end
        eng_i_ready = eir;
        eov         = force_eov || (eov_req && eng_q.size() > 0);
        eng_o_valid = eov;
        eng_o_data  = (eng_q.size() > 0) ? (eng_q[0] ^ MASK) : '0;
        rsp_ready   = rr_in;
        #1;
        obs_req_ready   = req_ready;
        obs_rsp_valid   = rsp_valid;
        obs_eng_i_data  = eng_i_data;
        obs_eng_i_valid = eng_i_valid;
        obs_rsp_data    = rsp_data;
        obs_rsp_hdr     = rsp_hdr;
        obs_eng_o_ready = eng_o_ready;
        obs_err         = err;

        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && rv[(rr_m + k) % N]) w = (rr_m + k) % N;
        acc    = (w >= 0) && (tags.size() < 8) && (!hold_v || eir);
        exp_rr = acc ? N'(1 << w) : '0;
        chk("req_ready", obs_req_ready, exp_rr);
        chk("eng_i_valid", obs_eng_i_valid, hold_v);
        if (hold_v) chk("eng_i_data", obs_eng_i_data, hold_d);
        if (tags.size() > 0) begin
            exp_rv  = eov ? N'(1 << tags[0].src) : '0;
            exp_eor = rr_in[tags[0].src];
            chk("rsp_hdr", obs_rsp_hdr, tags[0].hdr);
            if (eov && eng_q.size() > 0) chk("rsp_data", obs_rsp_data, eng_q[0] ^ MASK);
        end else begin
            exp_rv  = '0;
            exp_eor = 0;
        end
        chk("rsp_valid", obs_rsp_valid, exp_rv);
        chk("eng_o_ready", obs_eng_o_ready, exp_eor);
        chk("err", obs_err, err_m);

        @(posedge clk);
        if (rst_in) begin
            model_reset();
        end else begin
            if (eov && tags.size() == 0) err_m = 1;
            if (hold_v && eir) eng_q.push_back(obs_eng_i_data);
            if (eov && tags.size() > 0 && exp_eor) begin
                void'(tags.pop_front());
                if (eng_q.size() > 0) void'(eng_q.pop_front());
            end
            if (acc) begin
                hold_d = d_a[w];
                hold_v = 1;
                tags.push_back('{src: w, hdr: h_a[w]});
                rr_m = (w + 1) % N;
            end else if (eir) begin
                hold_v = 0;
            end
        end
    endtask

    task automatic do_reset();
        rv = '0; eov_req = 0; force_eov = 0; eir = 1; rr_in = '1;
        rst_in = 1;
        cycle();
        rst_in = 0;
    endtask

    task automatic drain();
        int n = 0;
        rv = '0; eir = 1; eov_req = 1; rr_in = '1;
        while ((tags.size() > 0 || hold_v) && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_done", tags.size(), 0);
        eov_req = 0;
    endtask

    vec_t tbl[12];
    int   n_acc;
    logic [DW-1:0] d_stall;

    initial begin
        tbl[0]  = '{4'b1111, 1, 4'b0001};
        tbl[1]  = '{4'b1111, 1, 4'b0010};
        tbl[2]  = '{4'b1111, 1, 4'b0100};
        tbl[3]  = '{4'b1111, 1, 4'b1000};
        tbl[4]  = '{4'b1111, 1, 4'b0001};
        tbl[5]  = '{4'b1111, 1, 4'b0010};
        tbl[6]  = '{4'b1010, 1, 4'b1000};
        tbl[7]  = '{4'b1010, 1, 4'b0010};
        tbl[8]  = '{4'b0000, 1, 4'b0000};
        tbl[9]  = '{4'b0100, 0, 4'b0100};
        tbl[10] = '{4'b0100, 0, 4'b0000};
        tbl[11] = '{4'b0100, 1, 4'b0100};

        rst = 1; req_valid = '0; req_data = '0; req_hdr = '0;
        eng_i_ready = 0; eng_o_valid = 0; eng_o_data = '0; rsp_ready = '0;
        for (int i = 0; i < N; i++) begin d_a[i] = '0; h_a[i] = '0; end
        repeat (2) @(posedge clk);
        model_reset();
        do_reset();

        // Reset state
        cycle();
        chk("rst_eng_i_valid", obs_eng_i_valid, 0);
        chk("rst_err", obs_err, 0);
        chk("rst_req_ready", obs_req_ready, 0);
        chk("rst_rsp_valid", obs_rsp_valid, 0);

        // Single request from requester 1
        d_a[1] = {32{8'hA5}};
        h_a[1] = {2'd2, 2'd3, 12'd5};
        rv = 4'b0010;
        cycle();
        chk("single_req_ready", obs_req_ready, 4'b0010);
        rv = '0;
        cycle();
        chk("single_eng_i_valid", obs_eng_i_valid, 1);
        chk("single_eng_i_data", obs_eng_i_data, {32{8'hA5}});
        eov_req = 1;
        cycle();
        chk("single_rsp_valid", obs_rsp_valid, 4'b0010);
        chk("single_rsp_hdr", obs_rsp_hdr, {2'd2, 2'd3, 12'd5});
        chk("single_rsp_data", obs_rsp_data, {32{8'h11}});
        eov_req = 0;
        cycle();

        // Table: round-robin order and hold gating
        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < N; j++) begin d_a[j] = rand_data(); h_a[j] = HW'($urandom); end
            rv = tbl[i].rv; eir = tbl[i].eir; eov_req = 1; rr_in = '1;
            cycle();
            chk($sformatf("tbl%0d_req_ready", i), obs_req_ready, tbl[i].exp_ready);
        end
        drain();

        // Tag FIFO fill: exactly TAG_DEPTH accepts with no results
        do_reset();
        rv = '1; eir = 1; eov_req = 0; n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < N; j++) d_a[j] = rand_data();
            cycle();
            if (obs_req_ready != '0) n_acc++;
        end
        chk("fill_accepts", n_acc, 8);
        chk("fill_blocked", obs_req_ready, 0);
        eov_req = 1;
        cycle();
        chk("fill_pop_eng_o_ready", obs_eng_o_ready, 1);
        chk("fill_pop_req_ready", obs_req_ready, 0);
        eov_req = 0;
        cycle();
        chk("fill_one_more", $countones(obs_req_ready), 1);
        cycle();
        chk("fill_full_again", obs_req_ready, 0);
        drain();

        // Engine input stall with hold occupied
        do_reset();
        d_stall = rand_data();
        d_a[0] = d_stall;
        rv = 4'b0001; eir = 1;
        cycle();
        rv = '1; eir = 0;
        for (int i = 0; i < 5; i++) begin
            d_a[0] = rand_data();
            cycle();
            chk("stall_eng_i_data", obs_eng_i_data, d_stall);
            chk("stall_eng_i_valid", obs_eng_i_valid, 1);
            chk("stall_req_ready", obs_req_ready, 0);
        end
        eir = 1;
        cycle();
        chk("stall_resume", obs_req_ready, 4'b0010);
        drain();

        // In-order return to 3 then 0 with requester 3 stalled
        do_reset();
        rv = 4'b1000; cycle();
        rv = 4'b0001; cycle();
        rv = '0;      cycle();
        eov_req = 1; rr_in = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("order_stall_rsp_valid", obs_rsp_valid, 4'b1000);
            chk("order_stall_eng_o_ready", obs_eng_o_ready, 0);
        end
        rr_in = '1;
        cycle();
        chk("order_first_rsp_valid", obs_rsp_valid, 4'b1000);
        chk("order_first_eng_o_ready", obs_eng_o_ready, 1);
        cycle();
        chk("order_second_rsp_valid", obs_rsp_valid, 4'b0001);
        eov_req = 0;
        drain();

        // Result with no outstanding tag, then reset mid-stream
        do_reset();
        force_eov = 1;
        cycle();
        chk("err_eng_o_ready", obs_eng_o_ready, 0);
        chk("err_before", obs_err, 0);
        force_eov = 0;
        cycle();
        chk("err_set", obs_err, 1);
        rv = '1; eir = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("err_sticky", obs_err, 1);
        end
        rst_in = 1;
        cycle();
        rst_in = 0; rv = '0; eir = 1; force_eov = 1; rr_in = '1;
        cycle();
        chk("rst_mid_err", obs_err, 0);
        chk("rst_mid_eng_i_valid", obs_eng_i_valid, 0);
        chk("rst_mid_rsp_valid", obs_rsp_valid, 0);
        chk("rst_mid_eng_o_ready", obs_eng_o_ready, 0);
        force_eov = 0;
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < N; j++) begin d_a[j] = rand_data(); h_a[j] = HW'($urandom); end
            rv      = N'($urandom);
            eir     = ($urandom % 4) != 0;
            eov_req = ($urandom % 3) != 0;
            rr_in   = N'($urandom) | N'($urandom);
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
